// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC request arbiter.
package lpc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESP    = 2'd2,
      RECOVER = 2'd3
   } lpc_state_e;

   localparam logic       LPC_RD            = 1'b0;
   localparam logic       LPC_WR            = 1'b1;

   // Read byte returned to a requester whose transfer was aborted.
   localparam logic [7:0] LPC_TIMEOUT_RDATA = 8'hFF;

   // Width of the ISSUE watchdog counter.
   localparam int         LPC_TMO_CNT_W     = 16;

endpackage

// File: rtl/lpc_rr_pick.sv
// Two-input requester pick: round-robin on last_grant, or port 0 always
// wins a tie when FIXED_PRIO is nonzero.
module lpc_rr_pick
   import lpc_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic gnt_valid_o,
   output logic gnt_idx_o
);

   // Tie-break between simultaneous requests; a lone request always wins.
   always_comb begin
      gnt_valid_o = req0_i | req1_i;
      gnt_idx_o   = 1'b0;
      if (req0_i && req1_i) begin
         gnt_idx_o = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_i;
      end else if (req1_i) begin
         gnt_idx_o = 1'b1;
      end
   end

endmodule

// File: rtl/lpc_arbiter.sv
// Two-port arbiter/sequencer in front of the LPC host cycle engine.
// Port 0 is instruction fetch, port 1 is data load/store.
// Optional build macro: LPC_ARB_TIMEOUT_EN adds an ISSUE watchdog that
// aborts the engine and returns ack with err set and rdata 8'hFF.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transfer; pick a requester, latch its fields, raise m_go
// ISSUE   | m_go held; wait for m_done (or watchdog expiry)
// RESP    | one-cycle ack to the granted port; record last_grant
// RECOVER | wait for the engine to drop m_done before the next grant
module lpc_arbiter
   import lpc_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int FIXED_PRIO     = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              lclk,
   input  logic              lreset,

   input  logic              r0_req,
   input  logic              r0_dir,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [7:0]        r0_wdata,
   output logic [7:0]        r0_rdata,
   output logic              r0_ack,
   output logic              r0_err,

   input  logic              r1_req,
   input  logic              r1_dir,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [7:0]        r1_wdata,
   output logic [7:0]        r1_rdata,
   output logic              r1_ack,
   output logic              r1_err,

   output logic              m_go,
   output logic              m_dir,
   output logic [ADDR_W-1:0] m_addr,
   output logic [7:0]        m_wdata,
   input  logic [7:0]        m_rdata,
   input  logic              m_done,
   output logic              m_abort,

   output logic              busy
);

   lpc_state_e        state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              last_grant_q, last_grant_d;
   logic              dir_q, dir_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              go_q, go_d;
   logic [7:0]        rdata0_q, rdata0_d;
   logic [7:0]        rdata1_q, rdata1_d;
   logic              err_flag_q, err_flag_d;
   logic              abort_q, abort_d;

   logic              pick_valid;
   logic              pick_idx;
   logic              tmo_hit;

   lpc_rr_pick #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_pick (
      .req0_i       (r0_req),
      .req1_i       (r1_req),
      .last_grant_i (last_grant_q),
      .gnt_valid_o  (pick_valid),
      .gnt_idx_o    (pick_idx)
   );

`ifdef LPC_ARB_TIMEOUT_EN
   localparam logic [LPC_TMO_CNT_W-1:0] TMO_LAST =
      LPC_TMO_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [LPC_TMO_CNT_W-1:0] cnt_q, cnt_d;

   // Watchdog: held at zero outside a transfer, so it is clear on ISSUE entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == ISSUE) begin
         cnt_d = cnt_q + LPC_TMO_CNT_W'(1);
      end
   end

   // Watchdog count register.
   always_ff @(posedge lclk or posedge lreset) begin
      if (lreset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires in the last of TIMEOUT_CYCLES ISSUE cycles, so m_go is high
   // for exactly TIMEOUT_CYCLES cycles before the abort.
   assign tmo_hit = (cnt_q == TMO_LAST);
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign tmo_hit               = 1'b0;
`endif

   // Next-state and datapath update for the grant/issue/response sequence.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      dir_d        = dir_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      go_d         = go_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      err_flag_d   = err_flag_q;
      abort_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               gnt_d      = pick_idx;
               dir_d      = pick_idx ? r1_dir   : r0_dir;
               addr_d     = pick_idx ? r1_addr  : r0_addr;
               wdata_d    = pick_idx ? r1_wdata : r0_wdata;
               go_d       = 1'b1;
               err_flag_d = 1'b0;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (m_done) begin
               go_d = 1'b0;
               if (gnt_q) rdata1_d = m_rdata;
               else       rdata0_d = m_rdata;
               state_d = RESP;
            end else if (tmo_hit) begin
               go_d       = 1'b0;
               abort_d    = 1'b1;
               err_flag_d = 1'b1;
               if (gnt_q) rdata1_d = LPC_TIMEOUT_RDATA;
               else       rdata0_d = LPC_TIMEOUT_RDATA;
               state_d = RESP;
            end
         end
         RESP: begin
            last_grant_d = gnt_q;
            state_d      = RECOVER;
         end
         RECOVER: begin
            if (!m_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops m_go immediately.
   always_ff @(posedge lclk or posedge lreset) begin
      if (lreset) begin
         state_q      <= IDLE;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         dir_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         go_q         <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         err_flag_q   <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         dir_q        <= dir_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         go_q         <= go_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         err_flag_q   <= err_flag_d;
         abort_q      <= abort_d;
      end
   end

   assign m_go     = go_q;
   assign m_dir    = dir_q;
   assign m_addr   = addr_q;
   assign m_wdata  = wdata_q;
   assign m_abort  = abort_q;
   assign busy     = (state_q != IDLE);

   assign r0_ack   = (state_q == RESP) && !gnt_q;
   assign r1_ack   = (state_q == RESP) &&  gnt_q;
   assign r0_err   = r0_ack && err_flag_q;
   assign r1_err   = r1_ack && err_flag_q;
   assign r0_rdata = rdata0_q;
   assign r1_rdata = rdata1_q;

endmodule
